// File: rtl/ddr_arb_pkg.sv
// Shared constants, state type and ID helpers for the 3-channel DDR AXI arbiter.
package ddr_arb_pkg;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned ID_W     = 4;
  localparam int unsigned ID_CH_W  = 2;
  localparam int unsigned RR_REQ_W = NUM_CH;
  localparam int unsigned RR_IDX_W = ID_CH_W;

  typedef enum logic {Idle, Issue} arb_st_e;

  // Only IDs 0..2 map to a channel; anything else is a protocol error.
  function automatic logic id_bad(input logic [ID_W-1:0] id);
    return (id[ID_W-1:ID_CH_W] != '0) || (id[ID_CH_W-1:0] == 2'd3);
  endfunction

  function automatic logic [RR_IDX_W-1:0] next_ch(input logic [RR_IDX_W-1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

endpackage

// File: rtl/ddr_rr_arb.sv
// 3-way round-robin picker: first asserted request at or after ptr, wrapping.
module ddr_rr_arb
  import ddr_arb_pkg::*;
(
  input  logic [RR_REQ_W-1:0] req_i,
  input  logic [RR_IDX_W-1:0] ptr_i,
  output logic [RR_REQ_W-1:0] gnt_oh_o,
  output logic [RR_IDX_W-1:0] gnt_idx_o,
  output logic                any_o
);

  logic [RR_IDX_W-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = (ptr_i == 2'd3) ? 2'd0 : ptr_i;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any_o && req_i[idx]) begin
        any_o     = 1'b1;
        gnt_idx_o = idx;
      end
      idx = next_ch(idx);
    end
    if (any_o) gnt_oh_o = RR_REQ_W'(1) << gnt_idx_o;
  end

endmodule

// File: rtl/ddr_axi_arb_3ch.sv
// Shares the DDR3 controller's simplified-AXI user port among three requesters, with
// independent round-robin command arbitration per direction and ID-based data steering.
module ddr_axi_arb_3ch
  import ddr_arb_pkg::*;
#(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 32,
  parameter int unsigned MAX_OUTST       = 4
) (
  input  logic                           core_clk,
  input  logic                           resetn,
  input  logic                           ddr_init_done,
  input  logic [2:0]                     ch_wr_req,
  input  logic [3*CTRL_ADDR_WIDTH-1:0]   ch_wr_addr,
  input  logic [11:0]                    ch_wr_len,
  output logic [2:0]                     ch_wr_ack,
  input  logic [3*MEM_DQ_WIDTH*8-1:0]    ch_wdata,
  input  logic [3*MEM_DQ_WIDTH-1:0]      ch_wstrb,
  output logic [2:0]                     ch_wready,
  output logic [2:0]                     ch_wlast,
  input  logic [2:0]                     ch_rd_req,
  input  logic [3*CTRL_ADDR_WIDTH-1:0]   ch_rd_addr,
  input  logic [11:0]                    ch_rd_len,
  output logic [2:0]                     ch_rd_ack,
  output logic [MEM_DQ_WIDTH*8-1:0]      ch_rdata,
  output logic [2:0]                     ch_rvalid,
  output logic [2:0]                     ch_rlast,
  output logic [CTRL_ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [3:0]                     axi_awlen,
  output logic [3:0]                     axi_awuser_id,
  output logic                           axi_awuser_ap,
  output logic                           axi_awvalid,
  input  logic                           axi_awready,
  output logic [MEM_DQ_WIDTH*8-1:0]      axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]        axi_wstrb,
  input  logic                           axi_wready,
  input  logic [3:0]                     axi_wusero_id,
  input  logic                           axi_wusero_last,
  output logic [CTRL_ADDR_WIDTH-1:0]     axi_araddr,
  output logic [3:0]                     axi_arlen,
  output logic [3:0]                     axi_aruser_id,
  output logic                           axi_aruser_ap,
  output logic                           axi_arvalid,
  input  logic                           axi_arready,
  input  logic [MEM_DQ_WIDTH*8-1:0]      axi_rdata,
  input  logic [3:0]                     axi_rid,
  input  logic                           axi_rlast,
  input  logic                           axi_rvalid,
  output logic                           arb_err
);

  localparam int unsigned AW = CTRL_ADDR_WIDTH;
  localparam int unsigned DW = MEM_DQ_WIDTH * 8;
  localparam int unsigned SW = MEM_DQ_WIDTH;

  arb_st_e                  wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic [1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [3:0]               wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic [3:0]               wr_id_q, wr_id_d, rd_id_q, rd_id_d;
  logic [NUM_CH-1:0][2:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                     err_q, err_d;

  logic [2:0] wr_elig, rd_elig, wr_gnt_oh, rd_gnt_oh;
  logic [1:0] wr_gnt_idx, rd_gnt_idx;
  logic       wr_any, rd_any;
  logic [2:0] wr_sel, rd_sel, wr_cpl, rd_cpl, wr_dec, rd_dec;

  // Full channels drop out of arbitration; nothing is eligible before calibration.
  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_elig[i] = ch_wr_req[i] & (wr_cnt_q[i] != 3'(MAX_OUTST)) & ddr_init_done;
      rd_elig[i] = ch_rd_req[i] & (rd_cnt_q[i] != 3'(MAX_OUTST)) & ddr_init_done;
    end
  end

  ddr_rr_arb u_wr_arb (
    .req_i     (wr_elig),
    .ptr_i     (wr_ptr_q),
    .gnt_oh_o  (wr_gnt_oh),
    .gnt_idx_o (wr_gnt_idx),
    .any_o     (wr_any)
  );

  ddr_rr_arb u_rd_arb (
    .req_i     (rd_elig),
    .ptr_i     (rd_ptr_q),
    .gnt_oh_o  (rd_gnt_oh),
    .gnt_idx_o (rd_gnt_idx),
    .any_o     (rd_any)
  );

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_ptr_d  = wr_ptr_q;
    wr_addr_d = wr_addr_q;
    wr_len_d  = wr_len_q;
    wr_id_d   = wr_id_q;
    ch_wr_ack = '0;
    unique case (wr_st_q)
      Idle: begin
        if (wr_any) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (wr_gnt_oh[i]) begin
              wr_addr_d = ch_wr_addr[i*AW +: AW];
              wr_len_d  = ch_wr_len[i*4 +: 4];
            end
          end
          wr_id_d = {2'b00, wr_gnt_idx};
          wr_st_d = Issue;
        end
      end
      Issue: begin
        if (axi_awready) begin
          ch_wr_ack[wr_id_q[1:0]] = 1'b1;
          wr_ptr_d = next_ch(wr_id_q[1:0]);
          wr_st_d  = Idle;
        end
      end
    endcase
  end

  always_comb begin
    rd_st_d   = rd_st_q;
    rd_ptr_d  = rd_ptr_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    rd_id_d   = rd_id_q;
    ch_rd_ack = '0;
    unique case (rd_st_q)
      Idle: begin
        if (rd_any) begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (rd_gnt_oh[i]) begin
              rd_addr_d = ch_rd_addr[i*AW +: AW];
              rd_len_d  = ch_rd_len[i*4 +: 4];
            end
          end
          rd_id_d = {2'b00, rd_gnt_idx};
          rd_st_d = Issue;
        end
      end
      Issue: begin
        if (axi_arready) begin
          ch_rd_ack[rd_id_q[1:0]] = 1'b1;
          rd_ptr_d = next_ch(rd_id_q[1:0]);
          rd_st_d  = Idle;
        end
      end
    endcase
  end

  // A completion against an empty counter flags an error and leaves the count alone.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i]   = (axi_wusero_id == 4'(i));
      rd_sel[i]   = (axi_rid == 4'(i));
      wr_cpl[i]   = axi_wready & axi_wusero_last & wr_sel[i];
      rd_cpl[i]   = axi_rvalid & axi_rlast & rd_sel[i];
      wr_dec[i]   = wr_cpl[i] & (wr_cnt_q[i] != 3'd0);
      rd_dec[i]   = rd_cpl[i] & (rd_cnt_q[i] != 3'd0);
      wr_cnt_d[i] = wr_cnt_q[i] + 3'(ch_wr_ack[i]) - 3'(wr_dec[i]);
      rd_cnt_d[i] = rd_cnt_q[i] + 3'(ch_rd_ack[i]) - 3'(rd_dec[i]);
    end
    err_d = err_q | (axi_wready & id_bad(axi_wusero_id)) | (axi_rvalid & id_bad(axi_rid))
          | (|(wr_cpl & ~wr_dec)) | (|(rd_cpl & ~rd_dec));
  end

  always_comb begin
    unique case (axi_wusero_id[1:0])
      2'd0:    begin axi_wdata = ch_wdata[0*DW +: DW]; axi_wstrb = ch_wstrb[0*SW +: SW]; end
      2'd1:    begin axi_wdata = ch_wdata[1*DW +: DW]; axi_wstrb = ch_wstrb[1*SW +: SW]; end
      2'd2:    begin axi_wdata = ch_wdata[2*DW +: DW]; axi_wstrb = ch_wstrb[2*SW +: SW]; end
      default: begin axi_wdata = '0;                   axi_wstrb = '0;                   end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      wr_st_q   <= Idle;
      rd_st_q   <= Idle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_len_q  <= '0;
      rd_len_q  <= '0;
      wr_id_q   <= '0;
      rd_id_q   <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_len_q  <= wr_len_d;
      rd_len_q  <= rd_len_d;
      wr_id_q   <= wr_id_d;
      rd_id_q   <= rd_id_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
    end
  end

  assign axi_awaddr    = wr_addr_q;
  assign axi_awlen     = wr_len_q;
  assign axi_awuser_id = wr_id_q;
  assign axi_awuser_ap = 1'b1;
  assign axi_awvalid   = (wr_st_q == Issue);
  assign axi_araddr    = rd_addr_q;
  assign axi_arlen     = rd_len_q;
  assign axi_aruser_id = rd_id_q;
  assign axi_aruser_ap = 1'b1;
  assign axi_arvalid   = (rd_st_q == Issue);
  assign ch_wready     = {3{axi_wready}} & wr_sel;
  assign ch_wlast      = ch_wready & {3{axi_wusero_last}};
  assign ch_rdata      = axi_rdata;
  assign ch_rvalid     = {3{axi_rvalid}} & rd_sel;
  assign ch_rlast      = ch_rvalid & {3{axi_rlast}};
  assign arb_err       = err_q;

endmodule

// File: tb/tb_ddr_axi_arb_3ch.sv
// Directed bench for ddr_axi_arb_3ch: arbitration order, stalls, steering, limits, errors.
module tb_ddr_axi_arb_3ch;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam logic [DW-1:0] W1 = {8{32'hC1C1_0001}};
  localparam logic [SW-1:0] S1 = 32'hFFFF_0000;
  localparam logic [DW-1:0] RD = {8{32'hDEAD_BEEF}};

  logic            core_clk = 1'b0;
  logic            resetn = 1'b0;
  logic            ddr_init_done = 1'b0;
  logic [2:0]      ch_wr_req = '0, ch_rd_req = '0;
  logic [3*AW-1:0] ch_wr_addr, ch_rd_addr;
  logic [11:0]     ch_wr_len, ch_rd_len;
  logic [2:0]      ch_wr_ack, ch_rd_ack, ch_wready, ch_wlast, ch_rvalid, ch_rlast;
  logic [3*DW-1:0] ch_wdata;
  logic [3*SW-1:0] ch_wstrb;
  logic [DW-1:0]   ch_rdata, axi_wdata;
  logic [AW-1:0]   axi_awaddr, axi_araddr;
  logic [3:0]      axi_awlen, axi_awuser_id, axi_arlen, axi_aruser_id;
  logic            axi_awuser_ap, axi_awvalid, axi_aruser_ap, axi_arvalid;
  logic [SW-1:0]   axi_wstrb;
  logic            axi_awready = 1'b0, axi_arready = 1'b0, axi_wready = 1'b0;
  logic [3:0]      axi_wusero_id = '0, axi_rid = '0;
  logic            axi_wusero_last = 1'b0, axi_rlast = 1'b0, axi_rvalid = 1'b0;
  logic [DW-1:0]   axi_rdata = RD;
  logic            arb_err;

  int errors = 0;
  int checks = 0;

  always #5 core_clk = ~core_clk;

  ddr_axi_arb_3ch dut (
    .core_clk        (core_clk),
    .resetn          (resetn),
    .ddr_init_done   (ddr_init_done),
    .ch_wr_req       (ch_wr_req),
    .ch_wr_addr      (ch_wr_addr),
    .ch_wr_len       (ch_wr_len),
    .ch_wr_ack       (ch_wr_ack),
    .ch_wdata        (ch_wdata),
    .ch_wstrb        (ch_wstrb),
    .ch_wready       (ch_wready),
    .ch_wlast        (ch_wlast),
    .ch_rd_req       (ch_rd_req),
    .ch_rd_addr      (ch_rd_addr),
    .ch_rd_len       (ch_rd_len),
    .ch_rd_ack       (ch_rd_ack),
    .ch_rdata        (ch_rdata),
    .ch_rvalid       (ch_rvalid),
    .ch_rlast        (ch_rlast),
    .axi_awaddr      (axi_awaddr),
    .axi_awlen       (axi_awlen),
    .axi_awuser_id   (axi_awuser_id),
    .axi_awuser_ap   (axi_awuser_ap),
    .axi_awvalid     (axi_awvalid),
    .axi_awready     (axi_awready),
    .axi_wdata       (axi_wdata),
    .axi_wstrb       (axi_wstrb),
    .axi_wready      (axi_wready),
    .axi_wusero_id   (axi_wusero_id),
    .axi_wusero_last (axi_wusero_last),
    .axi_araddr      (axi_araddr),
    .axi_arlen       (axi_arlen),
    .axi_aruser_id   (axi_aruser_id),
    .axi_aruser_ap   (axi_aruser_ap),
    .axi_arvalid     (axi_arvalid),
    .axi_arready     (axi_arready),
    .axi_rdata       (axi_rdata),
    .axi_rid         (axi_rid),
    .axi_rlast       (axi_rlast),
    .axi_rvalid      (axi_rvalid),
    .arb_err         (arb_err)
  );

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ddr_init_done = 1'b0;
    ch_wr_req = '0;
    ch_rd_req = '0;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready = 1'b0;
    axi_wusero_id = '0;
    axi_wusero_last = 1'b0;
    axi_rvalid = 1'b0;
    axi_rlast = 1'b0;
    axi_rid = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Leaves the caller in the handshake cycle when ok=1.
  task automatic wait_aw(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (axi_awvalid && axi_awready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ar(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (axi_arvalid && axi_arready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (axi_awvalid !== 1'b0 || axi_arvalid !== 1'b0)
      begin errors++; $display("FAIL reset_valid: got aw=%b ar=%b want 0 0", axi_awvalid, axi_arvalid); end
    checks++;
    if (arb_err !== 1'b0 || ch_wr_ack !== 3'b0 || ch_rd_ack !== 3'b0)
      begin errors++; $display("FAIL reset_err_ack: got err=%b wack=%b rack=%b want 0", arb_err, ch_wr_ack, ch_rd_ack); end
    checks++;
    if (axi_awaddr !== '0 || axi_awlen !== 4'd0 || axi_awuser_id !== 4'd0)
      begin errors++; $display("FAIL reset_payload: got addr=%0h len=%0h id=%0h want 0", axi_awaddr, axi_awlen, axi_awuser_id); end
    checks++;
    if (axi_awuser_ap !== 1'b1 || axi_aruser_ap !== 1'b1)
      begin errors++; $display("FAIL user_ap: got aw=%b ar=%b want 1 1", axi_awuser_ap, axi_aruser_ap); end
  endtask

  task automatic test_rr_order();
    int seen;
    bit ok;
    logic [1:0] exp_id [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] exp_ack;
    do_reset();
    axi_awready = 1'b1;
    ch_wr_req = 3'b111;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (axi_awvalid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL init_gate: got %0d valid cycles want 0", seen); end
    ddr_init_done = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_aw(8, ok);
      exp_ack = 3'(1) << exp_id[g];
      checks++;
      if (!ok || axi_awuser_id !== {2'b00, exp_id[g]})
        begin errors++; $display("FAIL rr_order%0d: got ok=%b id=%0d want id %0d", g, ok, axi_awuser_id, exp_id[g]); end
      checks++;
      if (ch_wr_ack !== exp_ack)
        begin errors++; $display("FAIL rr_ack%0d: got %b want %b", g, ch_wr_ack, exp_ack); end
      if (g == 3) ch_wr_req = 3'b000;
      tick();
    end
    tick();
    tick();
    checks++;
    if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL rr_idle: got awvalid=%b want 0", axi_awvalid); end
  endtask

  task automatic test_stall_wdata();
    int ackcnt, bad;
    bit ok;
    do_reset();
    ddr_init_done = 1'b1;
    ch_wr_addr[AW +: AW] = 28'h0000400;
    ch_wr_len[4 +: 4] = 4'd3;
    ch_wr_req = 3'b010;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (axi_awvalid) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_valid: got no awvalid want awvalid within 6 cycles"); end
    ackcnt = 0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!axi_awvalid || axi_awaddr !== 28'h0000400 || axi_awlen !== 4'd3 || axi_awuser_id !== 4'd1)
        bad++;
      if (ch_wr_ack !== 3'b000) ackcnt++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
    axi_awready = 1'b1;
    #1;
    checks++;
    if (ch_wr_ack !== 3'b010) begin errors++; $display("FAIL stall_ack: got %b want 010", ch_wr_ack); end
    if (ch_wr_ack !== 3'b000) ackcnt++;
    ch_wr_req = 3'b000;
    tick();
    axi_awready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (ch_wr_ack !== 3'b000) ackcnt++;
      tick();
    end
    checks++;
    if (ackcnt !== 1) begin errors++; $display("FAIL stall_ack_once: got %0d ack cycles want 1", ackcnt); end
    checks++;
    if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL stall_drop: got awvalid=%b want 0", axi_awvalid); end

    axi_wusero_id = 4'd1;
    for (int b = 0; b < 4; b++) begin
      axi_wready = 1'b1;
      axi_wusero_last = (b == 3);
      #1;
      checks++;
      if (ch_wready !== 3'b010) begin errors++; $display("FAIL wready_b%0d: got %b want 010", b, ch_wready); end
      checks++;
      if (ch_wlast !== ((b == 3) ? 3'b010 : 3'b000))
        begin errors++; $display("FAIL wlast_b%0d: got %b want %b", b, ch_wlast, (b == 3) ? 3'b010 : 3'b000); end
      checks++;
      if (axi_wdata !== W1 || axi_wstrb !== S1)
        begin errors++; $display("FAIL wdata_b%0d: got strb=%0h data[31:0]=%0h want %0h %0h", b, axi_wstrb, axi_wdata[31:0], S1, W1[31:0]); end
      tick();
    end
    axi_wready = 1'b0;
    axi_wusero_last = 1'b0;
    #1;
    checks++;
    if (ch_wready !== 3'b000) begin errors++; $display("FAIL wready_idle: got %b want 000", ch_wready); end
    tick();
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL wdata_err: got %b want 0", arb_err); end
  endtask

  task automatic test_outst_limit();
    bit ok;
    int ch0_seen, other;
    do_reset();
    ddr_init_done = 1'b1;
    axi_arready = 1'b1;
    ch_rd_req = 3'b100;
    for (int g = 0; g < 4; g++) begin
      wait_ar(8, ok);
      checks++;
      if (!ok || axi_aruser_id !== 4'd2)
        begin errors++; $display("FAIL rd_fill%0d: got ok=%b id=%0d want id 2", g, ok, axi_aruser_id); end
      tick();
    end
    ch_rd_req = 3'b101;
    ch0_seen = 0;
    other = 0;
    for (int c = 0; c < 8; c++) begin
      if (axi_arvalid && axi_arready) begin
        if (axi_aruser_id === 4'd0) begin ch0_seen++; ch_rd_req[0] = 1'b0; end
        else other++;
      end
      tick();
    end
    checks++;
    if (ch0_seen !== 1) begin errors++; $display("FAIL rd_ch0_pass: got %0d ch0 grants want 1", ch0_seen); end
    checks++;
    if (other !== 0) begin errors++; $display("FAIL rd_ch2_full: got %0d extra grants want 0", other); end
    axi_rvalid = 1'b1;
    axi_rlast = 1'b1;
    axi_rid = 4'd2;
    #1;
    checks++;
    if (ch_rvalid !== 3'b100 || ch_rlast !== 3'b100)
      begin errors++; $display("FAIL rd_route: got rvalid=%b rlast=%b want 100 100", ch_rvalid, ch_rlast); end
    checks++;
    if (ch_rdata !== RD) begin errors++; $display("FAIL rd_data: got %0h want %0h", ch_rdata[31:0], RD[31:0]); end
    tick();
    axi_rvalid = 1'b0;
    axi_rlast = 1'b0;
    wait_ar(6, ok);
    checks++;
    if (!ok || axi_aruser_id !== 4'd2)
      begin errors++; $display("FAIL rd_fifth: got ok=%b id=%0d want id 2", ok, axi_aruser_id); end
    ch_rd_req = 3'b000;
    tick();
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", arb_err); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int nok, extra;
    do_reset();
    ddr_init_done = 1'b1;
    axi_awready = 1'b1;
    ch_wr_req = 3'b001;
    nok = 0;
    for (int g = 0; g < 4; g++) begin
      wait_aw(8, ok);
      if (!ok) nok++;
      if (g == 3) begin
        axi_wready = 1'b1;
        axi_wusero_id = 4'd0;
        axi_wusero_last = 1'b1;
      end
      tick();
      axi_wready = 1'b0;
      axi_wusero_last = 1'b0;
    end
    checks++;
    if (nok !== 0) begin errors++; $display("FAIL same_fill: got %0d missing grants want 0", nok); end
    wait_aw(6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL same_cycle_count: got no 5th grant want grant (count held at 3)"); end
    tick();
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (axi_awvalid) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL same_full: got %0d valid cycles want 0", extra); end
    ch_wr_req = 3'b000;
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL same_err: got %b want 0", arb_err); end
  endtask

  task automatic test_bad_id();
    logic [3:0] ids [2] = '{4'd3, 4'd6};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      axi_rvalid = 1'b1;
      axi_rid = ids[k];
      #1;
      checks++;
      if (ch_rvalid !== 3'b000) begin errors++; $display("FAIL bad_rid%0d_route: got %b want 000", ids[k], ch_rvalid); end
      tick();
      axi_rvalid = 1'b0;
      checks++;
      if (arb_err !== 1'b1) begin errors++; $display("FAIL bad_rid%0d_err: got %b want 1", ids[k], arb_err); end
    end
    do_reset();
    axi_wready = 1'b1;
    axi_wusero_id = 4'd5;
    #1;
    checks++;
    if (ch_wready !== 3'b000) begin errors++; $display("FAIL bad_wid_route: got %b want 000", ch_wready); end
    tick();
    axi_wready = 1'b0;
    checks++;
    if (arb_err !== 1'b1) begin errors++; $display("FAIL bad_wid_err: got %b want 1", arb_err); end
    do_reset();
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", arb_err); end
    axi_rvalid = 1'b1;
    axi_rlast = 1'b1;
    axi_rid = 4'd1;
    #1;
    checks++;
    if (ch_rvalid !== 3'b010) begin errors++; $display("FAIL underflow_route: got %b want 010", ch_rvalid); end
    tick();
    axi_rvalid = 1'b0;
    axi_rlast = 1'b0;
    checks++;
    if (arb_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", arb_err); end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    do_reset();
    ddr_init_done = 1'b1;
    axi_awready = 1'b1;
    ch_wr_req = 3'b001;
    wait_aw(8, ok);
    ch_wr_req = 3'b000;
    tick();
    axi_awready = 1'b0;
    axi_rvalid = 1'b1;
    axi_rid = 4'd3;
    tick();
    axi_rvalid = 1'b0;
    checks++;
    if (!ok || arb_err !== 1'b1) begin errors++; $display("FAIL rst_setup: got ok=%b err=%b want 1 1", ok, arb_err); end
    ch_wr_req = 3'b111;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (axi_awvalid) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok || axi_awuser_id !== 4'd1)
      begin errors++; $display("FAIL rst_pre_ptr: got ok=%b id=%0d want id 1", ok, axi_awuser_id); end
    resetn = 1'b0;
    tick();
    checks++;
    if (axi_awvalid !== 1'b0 || arb_err !== 1'b0 || ch_wr_ack !== 3'b000)
      begin errors++; $display("FAIL rst_mid: got aw=%b err=%b ack=%b want 0 0 000", axi_awvalid, arb_err, ch_wr_ack); end
    resetn = 1'b1;
    axi_awready = 1'b1;
    wait_aw(8, ok);
    checks++;
    if (!ok || axi_awuser_id !== 4'd0)
      begin errors++; $display("FAIL rst_ptr: got ok=%b id=%0d want id 0", ok, axi_awuser_id); end
    ch_wr_req = 3'b000;
    tick();
  endtask

  initial begin
    ch_wr_addr = {28'h0000300, 28'h0000200, 28'h0000100};
    ch_rd_addr = {28'h0000B00, 28'h0000A00, 28'h0000900};
    ch_wr_len  = {4'd2, 4'd1, 4'd0};
    ch_rd_len  = {4'd7, 4'd3, 4'd1};
    ch_wdata   = {{8{32'hC2C2_0002}}, W1, {8{32'hC0C0_0000}}};
    ch_wstrb   = {32'h0000_FFFF, S1, 32'h0F0F_0F0F};
    test_reset();
    test_rr_order();
    test_stall_wdata();
    test_outst_limit();
    test_same_cycle();
    test_bad_id();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
